// File: rtl/uart_rx_sniffer.sv
// 8N1 UART receiver with a small receive FIFO, sticky error flags and a good-byte counter.
// Latency: stop bit sampled 2+DIV/2+9*DIV cycles after the line falls; valid_o one cycle later.
// Backpressure: FIFO holds bytes while ready_i is low; a good byte arriving when full is dropped and flagged.
`timescale 1ns/1ps
module uart_rx_sniffer #(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BAUD_RATE   = 781250,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_i,
    input  logic        rx_en_i,
    input  logic        clr_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        frame_err_o,
    output logic        overflow_o,
    output logic [15:0] byte_cnt_o
);

    localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t        state;
    logic          rx_meta, rxs, rxs_d;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          push_vld;
    logic [7:0]    push_dat;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, push_ok;

    // rxs_d lets IDLE demand a genuine 1->0 edge rather than a low level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            push_vld    <= 1'b0;
            push_dat    <= '0;
            frame_err_o <= 1'b0;
            byte_cnt_o  <= '0;
        end else begin
            push_vld <= 1'b0;
            if (clr_i) begin
                frame_err_o <= 1'b0;
                byte_cnt_o  <= '0;
            end
            if (!rx_en_i) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rxs_d && !rxs) begin
                            state <= S_START;
                            cnt   <= '0;
                        end
                    end
                    S_START: begin
                        if (cnt == HALF_LAST) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= rxs ? S_IDLE : S_DATA;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_DATA: begin
                        if (cnt == FULL_LAST) begin
                            cnt            <= '0;
                            shreg[bit_idx] <= rxs;
                            bit_idx        <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7)
                                state <= S_STOP;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_STOP: begin
                        if (cnt == FULL_LAST) begin
                            cnt <= '0;
                            if (rxs) begin
                                push_vld <= 1'b1;
                                push_dat <= shreg;
                                state    <= S_IDLE;
                                // a count event in the clear cycle survives as 1
                                if (clr_i)
                                    byte_cnt_o <= 16'd1;
                                else if (byte_cnt_o != 16'hFFFF)
                                    byte_cnt_o <= byte_cnt_o + 16'd1;
                            end else begin
                                frame_err_o <= 1'b1;
                                state       <= S_BREAK;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_BREAK: begin
                        if (rxs) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign valid_o = (count != '0);
    assign pop     = valid_o && ready_i;
    assign push_ok = push_vld && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_o     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // data_o always mirrors the head; a push into an empty or draining FIFO bypasses mem
            if (pop) begin
                if (count > (AW+1)'(1))
                    data_o <= mem[rd_ptr + AW'(1)];
                else if (push_ok)
                    data_o <= push_dat;
            end else if (count == '0 && push_ok) begin
                data_o <= push_dat;
            end
            if (push_vld && !push_ok)
                overflow_o <= 1'b1;
            else if (clr_i)
                overflow_o <= 1'b0;
        end
    end

endmodule
